// File: rtl/mem_io_bridge.sv
// Memory/IO bridge behind the 16-bit multicycle CPU: block RAM pass-through, LED/switch/UART MMIO.
// Optional free-running cycle timer at 0xFF04 is built only when MMIO_TIMER_EN is defined.
module mem_io_bridge #(
    parameter int WIDTH        = 16,
    parameter int RAM_AW       = 14,
    parameter int SW_W         = 10,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_wr,
    input  logic [WIDTH-1:0]  mem_addr,
    input  logic [WIDTH-1:0]  writedata,
    output logic [WIDTH-1:0]  mem_out,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [WIDTH-1:0]  ram_wdata,
    input  logic [WIDTH-1:0]  ram_rdata,
    input  logic [SW_W-1:0]   switches,
    output logic [SW_W-1:0]   leds,
    output logic              uart_tx
);

    localparam logic [WIDTH-1:0] RAM_LIMIT  = WIDTH'('hF000);
    localparam logic [WIDTH-1:0] ADDR_LED   = WIDTH'('hFF00);
    localparam logic [WIDTH-1:0] ADDR_SW    = WIDTH'('hFF01);
    localparam logic [WIDTH-1:0] ADDR_DATA  = WIDTH'('hFF02);
    localparam logic [WIDTH-1:0] ADDR_STAT  = WIDTH'('hFF03);
    localparam logic [WIDTH-1:0] ADDR_TIMER = WIDTH'('hFF04);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    uart_state_t     state, state_nxt;
    logic [CW-1:0]   baud_cnt, baud_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [7:0]      tx_byte, tx_byte_nxt;
    logic            overrun, overrun_nxt;
    logic            busy, baud_done;
    logic            uart_wr, stat_wr, led_wr;
    logic            sel_ram;
    logic [WIDTH-1:0] io_rdata, io_next;
    logic [SW_W-1:0] sw_meta, sw_sync;
`ifdef MMIO_TIMER_EN
    logic [WIDTH-1:0] timer;
`endif

    assign ram_addr  = mem_addr[RAM_AW-1:0];
    assign ram_wdata = writedata;
    assign ram_we    = mem_wr && (mem_addr < RAM_LIMIT);

    assign led_wr    = mem_wr && (mem_addr == ADDR_LED);
    assign uart_wr   = mem_wr && (mem_addr == ADDR_DATA);
    assign stat_wr   = mem_wr && (mem_addr == ADDR_STAT);
    assign busy      = (state != IDLE);
    assign baud_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    // I/O read data is registered so every region shares the RAM's 1-cycle latency
    always_comb begin
        io_next = '0;
        case (mem_addr)
            ADDR_LED:   io_next = WIDTH'(leds);
            ADDR_SW:    io_next = WIDTH'(sw_sync);
            ADDR_STAT:  io_next = WIDTH'({overrun, busy});
`ifdef MMIO_TIMER_EN
            ADDR_TIMER: io_next = timer;
`endif
            default:    io_next = '0;
        endcase
    end

    assign mem_out = sel_ram ? ram_rdata : io_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_ram  <= 1'b0;
            io_rdata <= '0;
            leds     <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            sel_ram  <= (mem_addr < RAM_LIMIT);
            io_rdata <= io_next;
            sw_meta  <= switches;
            sw_sync  <= sw_meta;
            if (led_wr)
                leds <= writedata[SW_W-1:0];
        end
    end

`ifdef MMIO_TIMER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timer <= '0;
        else if (mem_wr && (mem_addr == ADDR_TIMER))
            timer <= writedata;
        else
            timer <= timer + WIDTH'(1);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_byte  <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            tx_byte  <= tx_byte_nxt;
            overrun  <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud_cnt;
        bit_nxt     = bit_cnt;
        tx_byte_nxt = tx_byte;
        uart_tx     = 1'b1;

        // set is evaluated after clear so a coincident set wins
        overrun_nxt = overrun;
        if (stat_wr)
            overrun_nxt = 1'b0;
        if (uart_wr && busy)
            overrun_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (uart_wr) begin
                    tx_byte_nxt = writedata[7:0];
                    baud_nxt    = '0;
                    bit_nxt     = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                uart_tx = tx_byte[bit_cnt];
                if (baud_done) begin
                    baud_nxt = '0;
                    if (bit_cnt == 3'd7)
                        state_nxt = STOP;
                    else
                        bit_nxt = bit_cnt + 3'd1;
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: randomized bus traffic against a behavioural address-map model.
module tb_mem_io_bridge;

    localparam int WIDTH  = 16;
    localparam int RAM_AW = 14;
    localparam int SW_W   = 10;
    localparam int CPB    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_wr;
    logic [WIDTH-1:0]  mem_addr;
    logic [WIDTH-1:0]  writedata;
    logic [WIDTH-1:0]  mem_out;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [WIDTH-1:0]  ram_wdata;
    logic [WIDTH-1:0]  ram_rdata;
    logic [SW_W-1:0]   switches;
    logic [SW_W-1:0]   leds;
    logic              uart_tx;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_mem [int];
    logic [9:0]  exp_leds;
    logic        exp_ov;

    always #5 clk = ~clk;

    mem_io_bridge #(
        .WIDTH(WIDTH),
        .RAM_AW(RAM_AW),
        .SW_W(SW_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_wr(mem_wr),
        .mem_addr(mem_addr),
        .writedata(writedata),
        .mem_out(mem_out),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .switches(switches),
        .leds(leds),
        .uart_tx(uart_tx)
    );

    // external synchronous block RAM, read-before-write
    logic [15:0] bram [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_we)
            bram[ram_addr] <= ram_wdata;
        ram_rdata <= bram[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_ref(input logic [15:0] a);
        int key;
        key = int'(a) % (1 << RAM_AW);
        if (exp_mem.exists(key))
            return exp_mem[key];
        return 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, output logic we_seen);
        mem_wr    = 1'b1;
        mem_addr  = a;
        writedata = d;
        #1;
        we_seen = ram_we;
        tick();
        mem_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic we_seen);
        mem_wr   = 1'b0;
        mem_addr = a;
        #1;
        we_seen = ram_we;
        tick();
        d = mem_out;
    endtask

    // call right after the write that started the frame; STAT is polled each cycle
    task automatic uart_frame(input logic [7:0] b, input bit inject, input logic [7:0] junk);
        logic exp_bit;
        logic ov_now;
        for (int n = 0; n < 10 * CPB; n++) begin
            if (n < CPB)
                exp_bit = 1'b0;
            else if (n >= 9 * CPB)
                exp_bit = 1'b1;
            else
                exp_bit = b[(n / CPB) - 1];
            chk($sformatf("uart_bit_n%0d", n), uart_tx, exp_bit);
            ov_now = exp_ov | (inject && n >= 7);
            if (n >= 1 && !(inject && n == 6))
                chk($sformatf("stat_busy_n%0d", n), mem_out, {14'b0, ov_now, 1'b1});
            if (inject && n == 5) begin
                mem_wr    = 1'b1;
                mem_addr  = 16'hFF02;
                writedata = {8'hC3, junk};
            end else begin
                mem_wr   = 1'b0;
                mem_addr = 16'hFF03;
            end
            tick();
        end
        if (inject)
            exp_ov = 1'b1;
        chk("stat_last_stop", mem_out, {14'b0, exp_ov, 1'b1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic        we;
        logic [15:0] d, a, v;
        logic [15:0] addrs [$];
        logic [9:0]  sw_old, sw_new;

        for (int i = 0; i < (1 << RAM_AW); i++)
            bram[i] = 16'h0000;
        exp_leds  = '0;
        exp_ov    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        writedata = 16'h0000;
        switches  = '0;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #1;
        chk("reset_uart_tx", uart_tx, 1'b1);
        chk("reset_leds", leds, 10'h000);
        chk("reset_mem_out", mem_out, 16'h0000);
        tick();
        tick();
        #2 reset = 1'b1;
        tick();
        bus_read(16'hFF03, d, we);
        chk("reset_stat", d, 16'h0000);

        // RAM: directed then randomized, including the region boundary and aliasing
        bus_write(16'h0010, 16'h1234, we);
        chk("ram_we_write", we, 1'b1);
        exp_mem[16'h0010] = 16'h1234;
        bus_read(16'h0010, d, we);
        chk("ram_we_read", we, 1'b0);
        chk("ram_read_0010", d, 16'h1234);
        bus_write(16'hEFFF, 16'hBEEF, we);
        chk("ram_we_efff", we, 1'b1);
        exp_mem[int'(16'hEFFF) % (1 << RAM_AW)] = 16'hBEEF;
        bus_write(16'hF000, 16'h5A5A, we);
        chk("ram_we_f000", we, 1'b0);
        bus_write(16'h4010, 16'h7777, we);
        chk("ram_we_alias", we, 1'b1);
        exp_mem[int'(16'h4010) % (1 << RAM_AW)] = 16'h7777;
        addrs.push_back(16'h0010);
        addrs.push_back(16'hEFFF);
        addrs.push_back(16'h3000);
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom_range(0, 16'hEFFF));
            v = 16'($urandom);
            bus_write(a, v, we);
            chk("ram_we_rand", we, 1'b1);
            exp_mem[int'(a) % (1 << RAM_AW)] = v;
            addrs.push_back(a);
        end
        foreach (addrs[i]) begin
            bus_read(addrs[i], d, we);
            chk($sformatf("ram_read_%04h", addrs[i]), d, mem_ref(addrs[i]));
        end

        // LEDs
        bus_write(16'hFF00, 16'h03A5, we);
        exp_leds = 10'h3A5;
        chk("led_we", we, 1'b0);
        chk("leds_3a5", leds, exp_leds);
        bus_read(16'hFF00, d, we);
        chk("led_read_3a5", d, {6'b0, exp_leds});
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom);
            bus_write(16'hFF00, v, we);
            exp_leds = v[9:0];
            chk("leds_rand", leds, exp_leds);
            bus_read(16'hFF00, d, we);
            chk("led_read_rand", d, {6'b0, exp_leds});
        end

        // switches: two-flop synchronizer delay
        sw_old = '0;
        for (int i = 0; i < 4; i++) begin
            sw_new   = (i == 0) ? 10'h155 : 10'($urandom);
            switches = sw_new;
            bus_read(16'hFF01, d, we);
            chk("sw_edge1_old", d, {6'b0, sw_old});
            bus_read(16'hFF01, d, we);
            chk("sw_edge2_old", d, {6'b0, sw_old});
            bus_read(16'hFF01, d, we);
            chk("sw_edge3_new", d, {6'b0, sw_new});
            sw_old = sw_new;
        end

        // unmapped space: writes ignored, reads zero
        v = 16'($urandom);
        bus_write(16'hF800, v, we);
        chk("f800_ram_we", we, 1'b0);
        chk("f800_leds", leds, exp_leds);
        bus_read(16'hF800, d, we);
        chk("f800_read", d, 16'h0000);
        bus_read(16'h3800, d, we);
        chk("f800_alias_ram", d, mem_ref(16'h3800));
        bus_read(16'hFF02, d, we);
        chk("uart_data_read", d, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            a = (i % 2 == 0) ? 16'($urandom_range(16'hFF05, 16'hFFFF))
                             : 16'($urandom_range(16'hF000, 16'hFEFF));
            bus_write(a, 16'($urandom), we);
            chk("unmapped_we", we, 1'b0);
            bus_read(a, d, we);
            chk($sformatf("unmapped_read_%04h", a), d, 16'h0000);
        end
        chk("unmapped_leds", leds, exp_leds);
        bus_read(16'hFF03, d, we);
        chk("unmapped_stat", d, 16'h0000);

        // UART: plain frame, then a frame with a dropped overrun write
        bus_write(16'hFF02, 16'hA755, we);
        uart_frame(8'h55, 1'b0, 8'h00);
        bus_read(16'hFF03, d, we);
        chk("stat_after_frame", d, 16'h0000);
        v = 16'($urandom);
        bus_write(16'hFF02, v, we);
        uart_frame(v[7:0], 1'b1, 8'hAA);
        bus_read(16'hFF03, d, we);
        chk("stat_overrun_idle", d, 16'h0002);

        // new frame of zeros, clear overrun while busy, then reset mid-DATA
        bus_write(16'hFF02, 16'h0000, we);
        bus_write(16'hFF03, 16'($urandom), we);
        exp_ov = 1'b0;
        bus_read(16'hFF03, d, we);
        chk("stat_cleared_busy", d, 16'h0001);
        for (int i = 0; i < 6; i++)
            tick();
        chk("uart_mid_data", uart_tx, 1'b0);

`ifdef MMIO_TIMER_EN
        // timer load is checked while the frame runs; the UART does not interact
        bus_write(16'hFF04, 16'hFFFE, we);
        tick();
        tick();
        tick();
        bus_read(16'hFF04, d, we);
        chk("timer_wrap", d, 16'h0001);
`else
        bus_write(16'hFF04, 16'hFFFE, we);
        tick();
        bus_read(16'hFF04, d, we);
        chk("timer_absent", d, 16'h0000);
`endif

        v = 16'($urandom) | 16'h0001;
        bus_write(16'hFF00, v, we);
        exp_leds = v[9:0];
        bus_read(16'hFF00, d, we);
        chk("pre_reset_mem_out", d, {6'b0, exp_leds});
        chk("pre_reset_uart", uart_tx, 1'b0);
        #3 reset = 1'b0;
        #1;
        exp_leds = '0;
        chk("async_reset_uart_tx", uart_tx, 1'b1);
        chk("async_reset_leds", leds, exp_leds);
        chk("async_reset_mem_out", mem_out, 16'h0000);
        #2 reset = 1'b1;
        tick();
        bus_read(16'hFF03, d, we);
        chk("stat_after_reset", d, 16'h0000);
        for (int i = 0; i < 12 * CPB; i++) begin
            chk("no_frame_resume", uart_tx, 1'b1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
